// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: holds one dot-product job in a local operand buffer and
// plays it into a MAC processing element in four steps: clear, stream, accumulate
// request, then wait for the result. It returns the result with a one-cycle done.
// Optional feature macro: MAC_FEEDER_GOLDEN_EN adds a shadow accumulator that
// checks the MAC answer and reports disagreement on 'mismatch'.
module mac_operand_feeder #(
    parameter int DEPTH     = 64,
    parameter int W_WIDTH   = 4,
    parameter int A_WIDTH   = 8,
    parameter int RES_WIDTH = 18,
    parameter int TIMEOUT   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic signed [W_WIDTH-1:0]    wr_weight,
    input  logic signed [A_WIDTH-1:0]    wr_activation,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   len,
    output logic                         mac_en,
    output logic                         mac_reset,
    output logic                         mac_data_valid,
    output logic signed [W_WIDTH-1:0]    mac_weight,
    output logic signed [A_WIDTH-1:0]    mac_activation,
    output logic                         mac_acc,
    input  logic                         mac_output_valid,
    input  logic signed [RES_WIDTH-1:0]  mac_output_result,
    output logic                         busy,
    output logic                         done,
    output logic signed [RES_WIDTH-1:0]  result,
    output logic                         timeout_err,
    output logic                         mismatch
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_ACC    = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                       r_state, w_next_state;
    logic signed [W_WIDTH-1:0]    r_buf_w [DEPTH];
    logic signed [A_WIDTH-1:0]    r_buf_a [DEPTH];
    logic [LW-1:0]                r_len, w_len, r_idx, w_idx, w_len_clamped;
    logic [CW-1:0]                r_cnt, w_cnt;
    logic                         r_mac_en, r_mac_reset, w_mac_reset;
    logic                         r_dv, w_dv, r_acc, w_acc, r_busy;
    logic                         r_done, w_done, r_terr, w_terr;
    logic                         r_mismatch, w_mismatch, w_load_pair, w_gold_diff;
    logic signed [W_WIDTH-1:0]    r_weight, w_weight, w_rd_w;
    logic signed [A_WIDTH-1:0]    r_act, w_act, w_rd_a;
    logic signed [RES_WIDTH-1:0]  r_result, w_result;

    // Job length above the buffer depth runs the whole buffer.
    assign w_len_clamped = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    assign w_rd_w        = r_buf_w[r_idx[AW-1:0]];
    assign w_rd_a        = r_buf_a[r_idx[AW-1:0]];

    // Operand buffer: only writable while idle so a running job never sees edits.
    always_ff @(posedge clk) begin
        if (wr_en && (r_state == S_IDLE)) begin
            r_buf_w[wr_addr] <= wr_weight;
            r_buf_a[wr_addr] <= wr_activation;
        end
    end

`ifdef MAC_FEEDER_GOLDEN_EN
    logic signed [RES_WIDTH-1:0] r_gold;

    function automatic logic signed [RES_WIDTH-1:0] pair_product(
        input logic signed [W_WIDTH-1:0] w,
        input logic signed [A_WIDTH-1:0] a
    );
        logic signed [W_WIDTH+A_WIDTH-1:0] p;
        p = w * a;
        return RES_WIDTH'(p);
    endfunction

    // Shadow accumulator tracks each pair as it is launched toward the MAC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gold <= {RES_WIDTH{1'b0}};
        end else if (r_state == S_IDLE) begin
            r_gold <= {RES_WIDTH{1'b0}};
        end else if (w_load_pair) begin
            r_gold <= r_gold + pair_product(w_rd_w, w_rd_a);
        end else begin
            r_gold <= r_gold;
        end
    end

    assign w_gold_diff = (r_gold != mac_output_result);
`else
    assign w_gold_diff = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus next value of every output, so outputs line up with state.
    always_comb begin
        w_next_state = r_state;
        w_len        = r_len;
        w_idx        = r_idx;
        w_cnt        = r_cnt;
        w_mac_reset  = 1'b0;
        w_dv         = 1'b0;
        w_acc        = 1'b0;
        w_done       = 1'b0;
        w_weight     = r_weight;
        w_act        = r_act;
        w_result     = r_result;
        w_terr       = r_terr;
        w_mismatch   = r_mismatch;
        w_load_pair  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_clamped == {LW{1'b0}}) begin
                        w_next_state = S_DONE;
                        w_done       = 1'b1;
                        w_result     = {RES_WIDTH{1'b0}};
                        w_terr       = 1'b0;
                        w_mismatch   = 1'b0;
                    end else begin
                        w_next_state = S_CLEAR;
                        w_mac_reset  = 1'b1;
                        w_len        = w_len_clamped;
                        w_idx        = {LW{1'b0}};
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CLEAR: begin
                w_next_state = S_STREAM;
                w_load_pair  = 1'b1;
            end
            S_STREAM: begin
                if (r_idx == r_len) begin
                    w_next_state = S_ACC;
                    w_acc        = 1'b1;
                end else begin
                    w_load_pair  = 1'b1;
                end
            end
            S_ACC: begin
                w_next_state = S_WAIT;
                w_cnt        = {CW{1'b0}};
            end
            S_WAIT: begin
                if (mac_output_valid) begin
                    w_next_state = S_DONE;
                    w_done       = 1'b1;
                    w_result     = mac_output_result;
                    w_terr       = 1'b0;
                    w_mismatch   = w_gold_diff;
                end else if (r_cnt == CW'(TIMEOUT)) begin
                    w_next_state = S_DONE;
                    w_done       = 1'b1;
                    w_result     = {RES_WIDTH{1'b0}};
                    w_terr       = 1'b1;
                    w_mismatch   = 1'b0;
                end else begin
                    w_cnt        = r_cnt + CW'(1'b1);
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (w_load_pair) begin
            w_dv     = 1'b1;
            w_weight = w_rd_w;
            w_act    = w_rd_a;
            w_idx    = r_idx + LW'(1'b1);
        end else begin
            w_dv     = 1'b0;
        end
    end

    // Datapath and output registers; mac_en rises on the first edge out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= {LW{1'b0}};
            r_idx       <= {LW{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_mac_en    <= 1'b0;
            r_mac_reset <= 1'b0;
            r_dv        <= 1'b0;
            r_acc       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_weight    <= {W_WIDTH{1'b0}};
            r_act       <= {A_WIDTH{1'b0}};
            r_result    <= {RES_WIDTH{1'b0}};
            r_terr      <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            r_len       <= w_len;
            r_idx       <= w_idx;
            r_cnt       <= w_cnt;
            r_mac_en    <= 1'b1;
            r_mac_reset <= w_mac_reset;
            r_dv        <= w_dv;
            r_acc       <= w_acc;
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= w_done;
            r_weight    <= w_weight;
            r_act       <= w_act;
            r_result    <= w_result;
            r_terr      <= w_terr;
            r_mismatch  <= w_mismatch;
        end
    end

    assign mac_en         = r_mac_en;
    assign mac_reset      = r_mac_reset;
    assign mac_data_valid = r_dv;
    assign mac_weight     = r_weight;
    assign mac_activation = r_act;
    assign mac_acc        = r_acc;
    assign busy           = r_busy;
    assign done           = r_done;
    assign result         = r_result;
    assign timeout_err    = r_terr;
    assign mismatch       = r_mismatch;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: a behavioural MAC answers the feeder, and every
// job is compared with a dot product computed from a bench-side copy of the buffer
// plus the cycle timing that is expected for each strobe.
module tb_mac_operand_feeder;
    localparam int DEPTH = 64;
    localparam int TO    = 32;
    localparam int M_OK = 0, M_BAD = 1, M_MUTE = 2;
`ifdef MAC_FEEDER_GOLDEN_EN
    localparam int GOLD = 1;
`else
    localparam int GOLD = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [5:0] wr_addr = 6'd0;
    logic signed [3:0] wr_weight = 4'sd0;
    logic signed [7:0] wr_activation = 8'sd0;
    logic start = 1'b0;
    logic [6:0] len = 7'd0;
    logic mac_en, mac_reset, mac_data_valid, mac_acc, busy, done, timeout_err, mismatch;
    logic signed [3:0] mac_weight;
    logic signed [7:0] mac_activation;
    logic signed [17:0] result;
    logic mac_output_valid = 1'b0;
    logic signed [17:0] mac_output_result = 18'sd0;

    mac_operand_feeder #(.DEPTH(DEPTH), .W_WIDTH(4), .A_WIDTH(8), .RES_WIDTH(18), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_weight(wr_weight),
        .wr_activation(wr_activation), .start(start), .len(len), .mac_en(mac_en),
        .mac_reset(mac_reset), .mac_data_valid(mac_data_valid), .mac_weight(mac_weight),
        .mac_activation(mac_activation), .mac_acc(mac_acc), .mac_output_valid(mac_output_valid),
        .mac_output_result(mac_output_result), .busy(busy), .done(done), .result(result),
        .timeout_err(timeout_err), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ref_w [DEPTH];
    int ref_a [DEPTH];
    int mac_mode = 0, mac_delay = 1;
    int n_assert = 0, n_fail = 0;

    int mac_sum = 0, dv_n = 0, dv_tot = 0, dv_first_t = 0, dv_last_t = 0;
    int rst_cnt = 0, rst_t = 0, acc_tot = 0, acc_t = 0, pend = 0;
    int done_cnt = 0, done_t = 0, done_res = 0, done_terr = 0, done_mm = 0, hold_viol = 0;
    logic signed [3:0] last_w = 4'sd0;
    logic signed [7:0] last_a = 8'sd0;

    // Behavioural MAC and event recorder; times are the edge at which a value is seen.
    always @(negedge clk) begin
        mac_output_valid <= 1'b0;
        if (rst || mac_data_valid) begin
            last_w <= mac_weight;
            last_a <= mac_activation;
        end else if (mac_weight !== last_w || mac_activation !== last_a) begin
            hold_viol <= hold_viol + 1;
        end
        if (mac_reset) begin
            rst_cnt <= rst_cnt + 1;
            rst_t   <= cyc + 1;
            mac_sum <= 0;
            dv_n    <= 0;
        end
        if (mac_data_valid) begin
            dv_tot    <= dv_tot + 1;
            dv_n      <= dv_n + 1;
            dv_last_t <= cyc + 1;
            if (dv_n == 0) dv_first_t <= cyc + 1;
            mac_sum <= mac_sum + int'(mac_weight) * int'(mac_activation);
        end
        if (mac_acc) begin
            acc_tot <= acc_tot + 1;
            acc_t   <= cyc + 1;
            if (mac_mode != M_MUTE) pend <= mac_delay;
        end
        if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                mac_output_valid  <= 1'b1;
                mac_output_result <= 18'((mac_mode == M_BAD) ? mac_sum - 1 : mac_sum);
            end
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_t    <= cyc + 1;
            done_res  <= int'(result);
            done_terr <= int'(timeout_err);
            done_mm   <= int'(mismatch);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int dot(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += ref_w[i] * ref_a[i];
        return s;
    endfunction

    function automatic int wrap_res(input int v);
        logic signed [17:0] t;
        t = 18'(v);
        return int'(t);
    endfunction

    task automatic write_pair(input int addr, input int w, input int a);
        wr_en = 1'b1;
        wr_addr = 6'(addr);
        wr_weight = 4'(w);
        wr_activation = 8'(a);
        ref_w[addr] = w;
        ref_a[addr] = a;
        step();
        wr_en = 1'b0;
    endtask

    task automatic run_job(input string tag, input int n_req, input int mode, input int dly,
                           input bit poke, input bit same_wr);
        int n_eff, exp_res, t0, b_rst, b_dv, b_acc, b_done, i;
        bit sp;
        n_eff = (n_req > DEPTH) ? DEPTH : n_req;
        mac_mode = mode;
        mac_delay = dly;
        b_rst = rst_cnt; b_dv = dv_tot; b_acc = acc_tot; b_done = done_cnt;
        start = 1'b1;
        len = 7'(n_req);
        if (same_wr) begin
            ref_w[0] = int'($urandom_range(15, 0)) - 8;
            ref_a[0] = int'($urandom_range(255, 0)) - 128;
            wr_en = 1'b1;
            wr_addr = 6'd0;
            wr_weight = 4'(ref_w[0]);
            wr_activation = 8'(ref_a[0]);
        end
        exp_res = wrap_res(dot(n_eff));
        if (mode == M_BAD) exp_res = wrap_res(exp_res - 1);
        if (mode == M_MUTE || n_eff == 0) exp_res = 0;
        t0 = cyc + 1;
        step();
        start = 1'b0;
        wr_en = 1'b0;
        len = 7'd0;
        if (poke) begin
            step();
            wr_en = 1'b1; wr_addr = 6'd0; wr_weight = 4'sd7; wr_activation = 8'sd5;
            step();
            wr_en = 1'b0;
        end
        sp = 1'b0;
        i = 0;
        while (done_cnt == b_done && i < 400) begin
            if (start) start = 1'b0;
            else if (poke && !sp && acc_tot != b_acc) begin
                start = 1'b1; len = 7'd1; sp = 1'b1;
            end
            step();
            i++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, done_cnt - b_done, 1);
        chk({tag, "_result"}, done_res, exp_res);
        chk({tag, "_terr"}, done_terr, (mode == M_MUTE && n_eff > 0) ? 1 : 0);
        chk({tag, "_mismatch"}, done_mm, (mode == M_BAD && n_eff > 0) ? GOLD : 0);
        if (n_eff == 0) begin
            chk({tag, "_done_t"}, done_t, t0 + 1);
            chk({tag, "_no_traffic"}, (rst_cnt - b_rst) + (dv_tot - b_dv) + (acc_tot - b_acc), 0);
        end else begin
            chk({tag, "_clr_t"}, rst_t, t0 + 1);
            chk({tag, "_dv_first"}, dv_first_t, t0 + 2);
            chk({tag, "_dv_count"}, dv_tot - b_dv, n_eff);
            chk({tag, "_dv_last"}, dv_last_t, t0 + 1 + n_eff);
            chk({tag, "_acc_t"}, acc_t, t0 + 2 + n_eff);
            chk({tag, "_done_t"}, done_t, (mode == M_MUTE) ? t0 + 3 + n_eff + TO + 1 : t0 + 3 + n_eff + dly);
        end
        repeat (3) step();
        chk({tag, "_one_done"}, done_cnt - b_done, 1);
        chk({tag, "_one_job"}, rst_cnt - b_rst, (n_eff > 0) ? 1 : 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_held"}, result, done_res);
        chk({tag, "_hold_pair"}, hold_viol, 0);
    endtask

    initial begin
        int b_rst, b_done, i, n, d;
        step();
        step();
        chk("rst_mac_en", mac_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mac_reset, mac_data_valid, mac_acc, done}, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {timeout_err, mismatch}, 0);
        rst = 1'b0;
        step();
        chk("mac_en_after_rst", mac_en, 1);

        for (int k = 0; k < DEPTH; k++) write_pair(k, 1, 2);
        run_job("ones64", 64, M_OK, 3, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) write_pair(k, -8, -128);
        run_job("neg4", 4, M_OK, 1, 1'b0, 1'b0);
        run_job("neg4_bad", 4, M_BAD, 2, 1'b0, 1'b0);
        run_job("len0", 0, M_OK, 1, 1'b0, 1'b0);
        run_job("timeout", 3, M_MUTE, 1, 1'b0, 1'b0);

        for (int k = 0; k < DEPTH; k++)
            write_pair(k, int'($urandom_range(15, 0)) - 8, int'($urandom_range(255, 0)) - 128);
        run_job("rnd8", 8, M_OK, 2, 1'b0, 1'b0);
        run_job("rnd8_poke", 8, M_OK, 5, 1'b1, 1'b0);
        run_job("clamp", 100, M_OK, 1, 1'b0, 1'b0);
        run_job("wr_start", 5, M_OK, 1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(64, 1));
            d = int'($urandom_range(4, 1));
            run_job("rnd_loop", n, M_OK, d, 1'b0, 1'b0);
        end

        mac_mode = M_OK;
        mac_delay = 1;
        b_rst = rst_cnt;
        b_done = done_cnt;
        start = 1'b1;
        len = 7'd64;
        step();
        start = 1'b0;
        i = 0;
        while ((rst_cnt == b_rst || dv_n < 10) && i < 100) begin
            step();
            i++;
        end
        chk("midrst_reached", (rst_cnt != b_rst && dv_n >= 10) ? 1 : 0, 1);
        rst = 1'b1;
        #1;
        chk("midrst_strobes", {mac_reset, mac_data_valid, mac_acc, done}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mac_en", mac_en, 0);
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("midrst_no_done", done_cnt - b_done, 0);
        chk("midrst_mac_en_back", mac_en, 1);
        run_job("after_rst", 16, M_OK, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
